fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage pipeline. Holds the program counter and drives the word address into the combinational instruction memory. Registers the returned word together with its PC into the IF/ID pipeline register. Supports stall and branch/jump redirect with wrong-path flush.

---
 rtl/fetch_stage.sv | 141 ++++++++++++++
 tb/tb_fetch_stage.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of a 5-stage pipeline.
// - Holds the program counter (pc_r) and drives its low IMEM_W bits to a
//   combinational instruction memory.
// - Captures the returned word and its PC in the IF/ID pipeline register.
// - Supports a decode hazard stall.
// - Supports a branch/jump redirect from EX that flushes the wrong-path word.
//
// Optional feature macro: FETCH_CNT_EN
//   defined   -> fetch_cnt_o counts instructions accepted into IF/ID.
//   undefined -> no counter logic; fetch_cnt_o is tied to zero.
//
// Parameters:
//   IMEM_W    instruction-memory byte-address width
//   RESET_PC  PC loaded on reset (word aligned)
//   NOP_INSTR word shown on if_id_instr_o while the IF/ID slot is invalid
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   stall_i        hold PC and IF/ID
//   redirect_i     load PC from redirect_pc_i, flush IF/ID
//   redirect_pc_i  redirect target byte address
//   imem_addr_o    byte address to instruction memory (pc_r[IMEM_W-1:0])
//   imem_rdata_i   instruction word, combinational from imem_addr_o
//   pc_o           current fetch PC
//   if_id_pc_o     PC of the IF/ID instruction
//   if_id_pc4_o    if_id_pc_o + 4 (mod 2^32)
//   if_id_instr_o  IF/ID instruction, NOP_INSTR when invalid
//   if_id_valid_o  IF/ID slot valid
//   misalign_o     one-cycle pulse: accepted redirect target not word aligned
//   fetch_cnt_o    number of instructions accepted into IF/ID
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter int          IMEM_W    = 13,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [31:0]       redirect_pc_i,
    output logic [IMEM_W-1:0] imem_addr_o,
    input  logic [31:0]       imem_rdata_i,
    output logic [31:0]       pc_o,
    output logic [31:0]       if_id_pc_o,
    output logic [31:0]       if_id_pc4_o,
    output logic [31:0]       if_id_instr_o,
    output logic              if_id_valid_o,
    output logic              misalign_o,
    output logic [31:0]       fetch_cnt_o
);

    // Force a byte address onto a word boundary; pc_r[1:0] stays zero.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // Non-zero low bits mean the target was not word aligned.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return |addr[1:0];
    endfunction

    logic [31:0] pc_r;
    logic        run_r;
    logic [31:0] if_id_pc_r;
    logic [31:0] if_id_pc4_r;
    logic [31:0] if_id_instr_r;
    logic        if_id_valid_r;
    logic        misalign_r;
    logic        advance_s;

    // A normal fetch only happens once the stage is running; the first cycle
    // after reset is spent presenting RESET_PC to the memory.
    assign advance_s = run_r & ~stall_i & ~redirect_i;

    // PC, run flag, IF/ID register and misalignment pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_r          <= RESET_PC;
            run_r         <= 1'b0;
            if_id_pc_r    <= 32'h0000_0000;
            if_id_pc4_r   <= 32'h0000_0004;
            if_id_instr_r <= NOP_INSTR;
            if_id_valid_r <= 1'b0;
            misalign_r    <= 1'b0;
        end else begin
            run_r <= 1'b1;
            if (redirect_i) begin
                // Redirect wins over stall; the word fetched this cycle is
                // wrong-path and is dropped. IF/ID pc/pc4 are left unchanged.
                pc_r          <= word_align(redirect_pc_i);
                if_id_instr_r <= NOP_INSTR;
                if_id_valid_r <= 1'b0;
                misalign_r    <= is_misaligned(redirect_pc_i);
            end else if (advance_s) begin
                pc_r          <= pc_r + 32'd4;
                if_id_pc_r    <= pc_r;
                if_id_pc4_r   <= pc_r + 32'd4;
                if_id_instr_r <= imem_rdata_i;
                if_id_valid_r <= 1'b1;
                misalign_r    <= 1'b0;
            end else begin
                // Stall, or the idle first cycle after reset: hold everything.
                misalign_r    <= 1'b0;
            end
        end
    end

`ifdef FETCH_CNT_EN
    logic [31:0] fetch_cnt_r;

    // Count every edge that loads a valid instruction into IF/ID.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_cnt_r <= 32'd0;
        end else if (advance_s) begin
            fetch_cnt_r <= fetch_cnt_r + 32'd1;
        end else begin
            fetch_cnt_r <= fetch_cnt_r;
        end
    end

    assign fetch_cnt_o = fetch_cnt_r;
`else
    assign fetch_cnt_o = 32'd0;
`endif

    // The address depends only on pc_r, never directly on stall/redirect.
    assign imem_addr_o   = pc_r[IMEM_W-1:0];
    assign pc_o          = pc_r;
    assign if_id_pc_o    = if_id_pc_r;
    assign if_id_pc4_o   = if_id_pc4_r;
    assign if_id_instr_o = if_id_instr_r;
    assign if_id_valid_o = if_id_valid_r;
    assign misalign_o    = misalign_r;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Self-checking bench for fetch_stage. A behavioural model of the fetch stage
// tracks the expected PC/valid/misalign/counter values. Every accepted fetch
// pushes its expected IF/ID entry {pc, word} onto a scoreboard queue; the entry
// is popped and compared when the DUT presents it in IF/ID.
// Memory model: word at address A is {19'b0, A[12:0]}.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [12:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        misalign;
    logic [31:0] fetch_cnt;

    int err_cnt;
    int chk_cnt;

    entry_t sb[$];

    // Model state
    logic [31:0] m_pc;
    logic        m_run;
    logic        m_valid;
    logic [31:0] m_ifpc;
    logic        m_mis;
    logic [31:0] m_cnt;

    fetch_stage dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_addr_o   (imem_addr),
        .imem_rdata_i  (imem_rdata),
        .pc_o          (pc),
        .if_id_pc_o    (if_id_pc),
        .if_id_pc4_o   (if_id_pc4),
        .if_id_instr_o (if_id_instr),
        .if_id_valid_o (if_id_valid),
        .misalign_o    (misalign),
        .fetch_cnt_o   (fetch_cnt)
    );

    assign imem_rdata = {19'd0, imem_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance the model with the currently driven inputs, clock one edge,
    // then compare DUT outputs against the model and the scoreboard.
    task automatic step();
        entry_t e;
        logic   adv;
        adv = 1'b0;
        if (rst) begin
            m_pc    = 32'h0000_0000;
            m_run   = 1'b0;
            m_valid = 1'b0;
            m_ifpc  = 32'h0000_0000;
            m_mis   = 1'b0;
            m_cnt   = 32'd0;
            sb.delete();
        end else begin
            if (redirect) begin
                m_pc    = {redirect_pc[31:2], 2'b00};
                m_valid = 1'b0;
                m_mis   = |redirect_pc[1:0];
            end else if (stall) begin
                m_mis = 1'b0;
            end else if (m_run) begin
                adv      = 1'b1;
                e.pc     = m_pc;
                e.instr  = {19'd0, m_pc[12:0]};
                sb.push_back(e);
                m_ifpc   = m_pc;
                m_valid  = 1'b1;
                m_pc     = m_pc + 32'd4;
                m_cnt    = m_cnt + 32'd1;
                m_mis    = 1'b0;
            end else begin
                m_mis = 1'b0;
            end
            m_run = 1'b1;
        end
        @(posedge clk);
        #1;
        check_eq("pc", pc, m_pc);
        check_eq("imem_addr", {19'd0, imem_addr}, {19'd0, m_pc[12:0]});
        check_eq("valid", {31'd0, if_id_valid}, {31'd0, m_valid});
        check_eq("misalign", {31'd0, misalign}, {31'd0, m_mis});
`ifdef FETCH_CNT_EN
        check_eq("fetch_cnt", fetch_cnt, m_cnt);
`else
        check_eq("fetch_cnt", fetch_cnt, 32'd0);
`endif
        check_eq("if_id_pc", if_id_pc, m_ifpc);
        check_eq("if_id_pc4", if_id_pc4, m_ifpc + 32'd4);
        if (adv && (sb.size() != 0)) begin
            e = sb.pop_front();
            check_eq("sb_pc", if_id_pc, e.pc);
            check_eq("sb_instr", if_id_instr, e.instr);
            check_eq("sb_pc4", if_id_pc4, e.pc + 32'd4);
        end
        if (!m_valid) begin
            check_eq("nop_instr", if_id_instr, NOP);
        end
    endtask

    initial begin
        err_cnt     = 0;
        chk_cnt     = 0;
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0000_0000;

        // Reset state
        step();
        step();
        check_eq("rst_pc", pc, 32'h0000_0000);
        check_eq("rst_ifpc", if_id_pc, 32'h0000_0000);
        check_eq("rst_instr", if_id_instr, NOP);
        check_eq("rst_valid", {31'd0, if_id_valid}, 32'd0);

        // Release: first edge fetches RESET_PC, valid from the second edge
        rst = 1'b0;
        step();
        check_eq("rel1_valid", {31'd0, if_id_valid}, 32'd0);
        check_eq("rel1_pc", pc, 32'h0000_0000);
        step();
        check_eq("rel2_ifpc", if_id_pc, 32'h0000_0000);
        check_eq("rel2_valid", {31'd0, if_id_valid}, 32'd1);
        step();
        check_eq("rel3_ifpc", if_id_pc, 32'h0000_0004);
        step();
        check_eq("rel4_ifpc", if_id_pc, 32'h0000_0008);
        step();
        check_eq("pre_stall_pc", pc, 32'h0000_0010);

        // Stall for three cycles at pc 0x10
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("stall_pc", pc, 32'h0000_0010);
            check_eq("stall_ifpc", if_id_pc, 32'h0000_000C);
            check_eq("stall_valid", {31'd0, if_id_valid}, 32'd1);
        end
        stall = 1'b0;
        step();
        check_eq("resume_pc", pc, 32'h0000_0014);
        check_eq("resume_ifpc", if_id_pc, 32'h0000_0010);

        // Redirect to 0x40: one bubble
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0040;
        step();
        redirect = 1'b0;
        check_eq("redir_pc", pc, 32'h0000_0040);
        check_eq("redir_instr", if_id_instr, 32'h0000_0013);
        step();
        check_eq("redir_target", if_id_pc, 32'h0000_0040);

        // Redirect together with stall, misaligned target
        redirect    = 1'b1;
        stall       = 1'b1;
        redirect_pc = 32'h0000_0102;
        step();
        redirect = 1'b0;
        stall    = 1'b0;
        check_eq("mis_pc", pc, 32'h0000_0100);
        check_eq("mis_pulse", {31'd0, misalign}, 32'd1);
        step();
        check_eq("mis_clear", {31'd0, misalign}, 32'd0);

        // Back-to-back redirects, last wins
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        step();
        redirect_pc = 32'h0000_0300;
        step();
        redirect = 1'b0;
        check_eq("b2b_pc", pc, 32'h0000_0300);
        step();
        check_eq("b2b_ifpc", if_id_pc, 32'h0000_0300);

        // PC wrap
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        step();
        check_eq("wrap_pc", pc, 32'h0000_0000);
        check_eq("wrap_ifpc", if_id_pc, 32'hFFFF_FFFC);
        check_eq("wrap_pc4", if_id_pc4, 32'h0000_0000);

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            redirect    = ($urandom_range(0, 9) == 0);
            stall       = ($urandom_range(0, 9) < 3);
            redirect_pc = $urandom();
            step();
        end
        redirect = 1'b0;
        stall    = 1'b0;

        // Counter scenario: reset, 5 advances, 2 stalls, 1 redirect
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        for (int i = 0; i < 5; i++) step();
        stall = 1'b1;
        step();
        step();
        stall       = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0080;
        step();
        redirect = 1'b0;
`ifdef FETCH_CNT_EN
        check_eq("cnt_five", fetch_cnt, 32'd5);
`else
        check_eq("cnt_tied", fetch_cnt, 32'd0);
`endif
        step();
        step();

        // Reset mid-run
        rst = 1'b1;
        step();
        check_eq("midrst_pc", pc, 32'h0000_0000);
        check_eq("midrst_cnt", fetch_cnt, 32'd0);
        check_eq("midrst_valid", {31'd0, if_id_valid}, 32'd0);
        rst = 1'b0;
        step();
        step();
        step();

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
